// File: rtl/mmr_arbiter_if.sv
// Shared MMR bus port: the arbiter drives the access, and the addressed target
// returns read data and, in timeout builds, a ready strobe.
interface mmr_arbiter_if;
   logic        bus_en;
   logic        bus_rw;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rdy;

   modport master (
      output bus_en, bus_rw, bus_addr, bus_wdata,
      input  bus_rdata, bus_rdy
   );

   modport slave (
      input  bus_en, bus_rw, bus_addr, bus_wdata,
      output bus_rdata, bus_rdy
   );
endinterface

// File: rtl/mmr_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for one shared MMR bus port.
// Optional feature macro MMR_ARB_TIMEOUT_EN: bus_rdy-terminated access with TIMEOUT abort.
module mmr_arbiter #(
   parameter int unsigned HOLD    = 1,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        rw0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic [31:0] rdata0,
   output logic        ack0,
   output logic        err0,
   input  logic        req1,
   input  logic        rw1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic [31:0] rdata1,
   output logic        ack1,
   output logic        err1,
   mmr_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

`ifdef MMR_ARB_TIMEOUT_EN
   localparam logic [7:0] WINDOW_LOAD = 8'(TIMEOUT - 1);
`else
   localparam logic [7:0] WINDOW_LOAD = 8'(HOLD - 1);
`endif

   state_t      state;
   logic        last;
   logic        sel;
   logic [7:0]  count;
   logic        bus_en_q;
   logic        bus_rw_q;
   logic [31:0] bus_addr_q;
   logic [31:0] bus_wdata_q;

   logic        grant1;
   logic        access_end;
   logic        access_to;
   logic [31:0] rd_value;

   // With both requesting, requester 1 wins only when requester 0 was served last.
   assign grant1 = req1 & (~req0 | ~last);

`ifdef MMR_ARB_TIMEOUT_EN
   assign access_end = bus.bus_rdy | (count == 8'd0);
   assign access_to  = ~bus.bus_rdy & (count == 8'd0);
`else
   logic unused_rdy;
   assign unused_rdy = bus.bus_rdy;
   assign access_end = (count == 8'd0);
   assign access_to  = 1'b0;
`endif

   assign rd_value = access_to ? 32'hFFFF_FFFF : bus.bus_rdata;

   assign bus.bus_en    = bus_en_q;
   assign bus.bus_rw    = bus_rw_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;

   // NOTE: every output is a flop cleared by the async reset, so reset forces
   // them low in the same cycle; sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last        <= 1'b1;
         sel         <= 1'b0;
         count       <= 8'd0;
         bus_en_q    <= 1'b0;
         bus_rw_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         rdata0      <= 32'd0;
         rdata1      <= 32'd0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         err0        <= 1'b0;
         err1        <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  sel         <= grant1;
                  last        <= grant1;
                  bus_en_q    <= 1'b1;
                  bus_rw_q    <= grant1 ? rw1 : rw0;
                  bus_addr_q  <= grant1 ? addr1 : addr0;
                  bus_wdata_q <= grant1 ? wdata1 : wdata0;
                  count       <= WINDOW_LOAD;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (access_end) begin
                  bus_en_q <= 1'b0;
                  if (!bus_rw_q) begin
                     if (sel) rdata1 <= rd_value;
                     else     rdata0 <= rd_value;
                  end
                  if (sel) begin
                     ack1 <= 1'b1;
                     err1 <= access_to;
                  end else begin
                     ack0 <= 1'b1;
                     err0 <= access_to;
                  end
                  state <= DONE;
               end else begin
                  count <= count - 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   hold_legal: assert property (@(posedge clk) disable iff (!reset_n)
      (HOLD >= 1) && (HOLD <= 255))
      else $error("mmr_arbiter: HOLD out of range 1..255");

`ifdef MMR_ARB_TIMEOUT_EN
   timeout_legal: assert property (@(posedge clk) disable iff (!reset_n)
      (TIMEOUT >= 1) && (TIMEOUT <= 255))
      else $error("mmr_arbiter: TIMEOUT out of range 1..255");
`endif

   ack_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      !(ack0 && ack1))
      else $error("mmr_arbiter: both acks high");

   err_with_ack: assert property (@(posedge clk) disable iff (!reset_n)
      (err0 |-> ack0) and (err1 |-> ack1))
      else $error("mmr_arbiter: err without ack");

   bus_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (state == ACCESS && !access_end) |=> ($stable(bus_addr_q) && $stable(bus_rw_q)
                                            && $stable(bus_wdata_q) && bus_en_q))
      else $error("mmr_arbiter: bus changed inside access window");

endmodule

// File: tb/tb_mmr_arbiter.sv
// Self-checking bench for mmr_arbiter: a cycle-numbered transaction model checks
// every cycle, and directed scenarios pin hand-computed values.
module tb_mmr_arbiter;
   localparam int HOLD    = 2;
   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic [31:0] rdata0, rdata1;
   logic        ack0, ack1, err0, err1;

   mmr_arbiter_if bus ();

   mmr_arbiter #(.HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .req0   (req0),
      .rw0    (rw0),
      .addr0  (addr0),
      .wdata0 (wdata0),
      .rdata0 (rdata0),
      .ack0   (ack0),
      .err0   (err0),
      .req1   (req1),
      .rw1    (rw1),
      .addr1  (addr1),
      .wdata1 (wdata1),
      .rdata1 (rdata1),
      .ack1   (ack1),
      .err1   (err1),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction model: a grant at cycle g occupies the bus from g+1 until the
   // cycle before its ack; the ack cycle is fixed once the window's end is known.
   int          cyc = 0;
   bit          m_active = 0, m_w = 0, m_to = 0, m_last = 1, m_rw = 0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic [31:0] m_rdata [2] = '{32'd0, 32'd0};
   int          m_grant = 0, m_ack = -1;
   bit          in_win, is_ack, end_now;

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         m_active   = 0;
         m_last     = 1;
         m_rdata[0] = '0;
         m_rdata[1] = '0;
         check("reset bus_en", bus.bus_en, 0);
         check("reset bus_rw", bus.bus_rw, 0);
         check("reset bus_addr", bus.bus_addr, 0);
         check("reset bus_wdata", bus.bus_wdata, 0);
         check("reset ack0", ack0, 0);
         check("reset ack1", ack1, 0);
         check("reset err0", err0, 0);
         check("reset err1", err1, 0);
         check("reset rdata0", rdata0, 0);
         check("reset rdata1", rdata1, 0);
      end else begin
         in_win = m_active && (cyc > m_grant) && (m_ack < 0 || cyc < m_ack);
         is_ack = m_active && (cyc == m_ack);
         check("model bus_en", bus.bus_en, in_win);
         if (in_win) begin
            check("model bus_rw", bus.bus_rw, m_rw);
            check("model bus_addr", bus.bus_addr, m_addr);
            if (m_rw) check("model bus_wdata", bus.bus_wdata, m_wdata);
         end
         check("model ack0", ack0, is_ack && !m_w);
         check("model ack1", ack1, is_ack && m_w);
         check("model err0", err0, is_ack && !m_w && m_to);
         check("model err1", err1, is_ack && m_w && m_to);
         check("model rdata0", rdata0, m_rdata[0]);
         check("model rdata1", rdata1, m_rdata[1]);

         if (is_ack) begin
            m_active = 0;
         end else if (in_win && m_ack < 0) begin
`ifdef MMR_ARB_TIMEOUT_EN
            m_to    = !bus.bus_rdy && (cyc - m_grant == TIMEOUT);
            end_now = bus.bus_rdy || m_to;
`else
            m_to    = 0;
            end_now = (cyc - m_grant == HOLD);
`endif
            if (end_now) begin
               m_ack = cyc + 1;
               if (!m_rw) m_rdata[m_w] = m_to ? 32'hFFFF_FFFF : bus.bus_rdata;
            end
         end else if (!m_active && (req0 || req1)) begin
            m_w      = (req0 && req1) ? !m_last : req1;
            m_last   = m_w;
            m_active = 1;
            m_grant  = cyc;
            m_ack    = -1;
            m_rw     = m_w ? rw1 : rw0;
            m_addr   = m_w ? addr1 : addr0;
            m_wdata  = m_w ? wdata1 : wdata0;
         end
      end
   end

   initial begin
      bus.bus_rdata = '0;
      bus.bus_rdy   = 1'b0;

      // Reset state
      tick();
      tick();
      check("t1 bus_en", bus.bus_en, 0);
      check("t1 ack0", ack0, 0);
      check("t1 rdata1", rdata1, 0);
      reset_n = 1'b1;

`ifndef MMR_ARB_TIMEOUT_EN
      // Single read by requester 0
      req0 = 1; rw0 = 0; addr0 = 32'h100; bus.bus_rdata = 32'hCAFE;
      tick();
      check("t2 c1 bus_en", bus.bus_en, 1);
      check("t2 c1 bus_addr", bus.bus_addr, 32'h100);
      check("t2 c1 bus_rw", bus.bus_rw, 0);
      tick();
      check("t2 c2 bus_en", bus.bus_en, 1);
      check("t2 c2 ack0", ack0, 0);
      tick();
      check("t2 c3 ack0", ack0, 1);
      check("t2 c3 bus_en", bus.bus_en, 0);
      check("t2 c3 rdata0", rdata0, 32'hCAFE);
      req0 = 0;
      tick();
      check("t2 c4 ack0", ack0, 0);
      check("t2 c4 rdata0", rdata0, 32'hCAFE);

      // Both held high after a fresh reset: grants alternate 0,1,0,1
      reset_n = 0;
      tick();
      reset_n = 1;
      req0 = 1; rw0 = 0; req1 = 1; rw1 = 0; addr1 = 32'h180; bus.bus_rdata = 32'h5555;
      for (int c = 1; c <= 16; c++) begin
         tick();
         check("t3 ack0", ack0, (c == 3) || (c == 11));
         check("t3 ack1", ack1, (c == 7) || (c == 15));
         if (c == 15) begin
            req0 = 0;
            req1 = 0;
         end
      end

      // Write by requester 1 leaves rdata1 alone
      req1 = 1; rw1 = 1; addr1 = 32'h200; wdata1 = 32'h1234; bus.bus_rdata = 32'hDEAD;
      for (int c = 1; c <= 2; c++) begin
         tick();
         check("t4 bus_en", bus.bus_en, 1);
         check("t4 bus_rw", bus.bus_rw, 1);
         check("t4 bus_addr", bus.bus_addr, 32'h200);
         check("t4 bus_wdata", bus.bus_wdata, 32'h1234);
      end
      tick();
      check("t4 ack1", ack1, 1);
      check("t4 ack0", ack0, 0);
      check("t4 rdata1", rdata1, 32'h5555);
      req1 = 0;

      // Request dropped mid-access still completes; reset mid-access aborts
      tick();
      req0 = 1; rw0 = 0; addr0 = 32'h104; bus.bus_rdata = 32'h0BAD;
      tick();
      req0 = 0;
      tick();
      tick();
      check("t5 ack0 dropped", ack0, 1);
      check("t5 rdata0", rdata0, 32'h0BAD);
      tick();
      req0 = 1;
      tick();
      check("t5 bus_en before reset", bus.bus_en, 1);
      reset_n = 0;
      #1;
      check("t5 bus_en in reset", bus.bus_en, 0);
      check("t5 rdata0 in reset", rdata0, 0);
      tick();
      check("t5 ack0 after abort", ack0, 0);
      reset_n = 1;
      req0 = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("t5 no late ack0", ack0, 0);
      end
`else
      // Timeout read: four ACCESS cycles, then ack0 with err0 and all-ones data
      req0 = 1; rw0 = 0; addr0 = 32'h300; bus.bus_rdata = 32'hCAFE;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check("t6 bus_en", bus.bus_en, 1);
      end
      tick();
      check("t6 ack0", ack0, 1);
      check("t6 err0", err0, 1);
      check("t6 bus_en", bus.bus_en, 0);
      check("t6 rdata0", rdata0, 32'hFFFF_FFFF);
      req0 = 0;
      tick();
      check("t6 err0 cleared", err0, 0);

      // Ready in the second ACCESS cycle
      req0 = 1; bus.bus_rdata = 32'hBEEF;
      tick();
      tick();
      bus.bus_rdy = 1;
      tick();
      check("t6 rdy ack0", ack0, 1);
      check("t6 rdy err0", err0, 0);
      check("t6 rdy rdata0", rdata0, 32'hBEEF);
      bus.bus_rdy = 0;
      req0 = 0;
      tick();

      // Timed-out write by requester 1 keeps rdata1
      req1 = 1; rw1 = 1; addr1 = 32'h400; wdata1 = 32'h77;
      for (int c = 1; c <= 5; c++) tick();
      check("t6 wr ack1", ack1, 1);
      check("t6 wr err1", err1, 1);
      check("t6 wr rdata1", rdata1, 0);
      check("t6 wr rdata0", rdata0, 32'hBEEF);
      req1 = 0;
      tick();
`endif

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
